// File: rtl/rp_gpr_dbg.sv
`default_nettype none
// ============================================================================
// Module   : rp_gpr_dbg
// Function : Debug-side GPR access sequencer (abstract register commands to
//            GPR read/write ports). Bursts enabled by RP_GPR_DBG_BURST_EN.
// Revision : 1.0  initial release
// ============================================================================
module rp_gpr_dbg #(
  parameter int AW = 5,
  parameter int XW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hlt,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_wr,
  input  logic [AW-1:0] req_adr,
  input  logic [AW-1:0] req_cnt,
  input  logic          wdt_vld,
  output logic          wdt_rdy,
  input  logic [XW-1:0] wdt_dat,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [XW-1:0] rsp_dat,
  output logic          rsp_lst,
  output logic          rsp_err,
  output logic          e_rs,
  output logic [AW-1:0] a_rs,
  input  logic [XW-1:0] d_rs,
  output logic          e_rd,
  output logic [AW-1:0] a_rd,
  output logic [XW-1:0] d_rd
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RSP  = 3'd2,
    S_WR   = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  state_t        r_st;
  logic [AW-1:0] r_adr;
  logic [XW-1:0] r_rsp_dat;
  logic          r_rsp_lst;
  logic          r_rsp_err;
  logic          w_last;

`ifdef RP_GPR_DBG_BURST_EN
  logic [AW-1:0] r_cnt;
  assign w_last = (r_cnt == '0);
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^req_cnt;
  assign w_last       = 1'b1;
`endif

  // Ready terms are masked by rst_n so every output reads 0 while in reset
  assign req_rdy = rst_n & hlt & (r_st == S_IDLE);
  assign wdt_rdy = rst_n & hlt & (r_st == S_WR);
  assign e_rs    = hlt & (r_st == S_RD);
  assign a_rs    = e_rs ? r_adr : '0;
  assign e_rd    = wdt_rdy & wdt_vld;
  assign a_rd    = e_rd ? r_adr : '0;
  assign d_rd    = e_rd ? wdt_dat : '0;
  assign rsp_vld = (r_st == S_RSP) | (r_st == S_ACK);
  assign rsp_dat = r_rsp_dat;
  assign rsp_lst = r_rsp_lst;
  assign rsp_err = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= S_IDLE;
      r_adr     <= '0;
      r_rsp_dat <= '0;
      r_rsp_lst <= 1'b0;
      r_rsp_err <= 1'b0;
`ifdef RP_GPR_DBG_BURST_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_st)
        S_IDLE: begin
          if (req_vld && hlt) begin
            r_adr     <= req_adr;
`ifdef RP_GPR_DBG_BURST_EN
            r_cnt     <= req_cnt;
`endif
            r_rsp_dat <= '0;
            r_rsp_lst <= 1'b0;
            r_rsp_err <= 1'b0;
            r_st      <= req_wr ? S_WR : S_RD;
          end
        end
        S_RD: begin
          if (hlt) begin
            r_rsp_dat <= d_rs;
            r_rsp_lst <= w_last;
            r_st      <= S_RSP;
          end else begin
            r_rsp_dat <= '0;
            r_rsp_lst <= 1'b1;
            r_rsp_err <= 1'b1;
            r_st      <= S_ACK;
          end
        end
        S_RSP: begin
          if (rsp_rdy) begin
            if (w_last) begin
              r_rsp_dat <= '0;
              r_rsp_lst <= 1'b0;
              r_st      <= S_IDLE;
            end else begin
              r_adr <= r_adr + AW'(1);
`ifdef RP_GPR_DBG_BURST_EN
              r_cnt <= r_cnt - AW'(1);
`endif
              r_st  <= S_RD;
            end
          end
        end
        S_WR: begin
          // Losing halt aborts the rest of the burst; unsent beats stay unconsumed
          if (!hlt) begin
            r_rsp_dat <= '0;
            r_rsp_lst <= 1'b1;
            r_rsp_err <= 1'b1;
            r_st      <= S_ACK;
          end else if (wdt_vld) begin
            if (w_last) begin
              r_rsp_dat <= '0;
              r_rsp_lst <= 1'b1;
              r_rsp_err <= 1'b0;
              r_st      <= S_ACK;
            end else begin
              r_adr <= r_adr + AW'(1);
`ifdef RP_GPR_DBG_BURST_EN
              r_cnt <= r_cnt - AW'(1);
`endif
            end
          end
        end
        S_ACK: begin
          if (rsp_rdy) begin
            r_rsp_lst <= 1'b0;
            r_rsp_err <= 1'b0;
            r_st      <= S_IDLE;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
